// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with combinational read ports, one write
// port, optional write-to-read forwarding, a per-register busy scoreboard and
// a post-reset engine that clears every register before the block goes live.
//
// state | meaning
// CLEAR | sweeping clr_idx over all registers, writing 0; ports gated off
// READY | normal operation; init_done=1
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NREAD  = 3,
  parameter int BYPASS = 1,
  localparam int IDXW  = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREAD*IDXW-1:0]   rs_idx,
  output logic [NREAD*XLEN-1:0]   rs_data,
  output logic [NREAD-1:0]        rs_busy,
  input  logic                    write_en,
  input  logic [IDXW-1:0]         write_rd,
  input  logic [XLEN-1:0]         data_in,
  input  logic                    reserve_en,
  input  logic [IDXW-1:0]         reserve_rd,
  input  logic [IDXW-1:0]         dbg_sel,
  output logic [XLEN-1:0]         dbg_data,
  output logic                    init_done
);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [IDXW-1:0]   clr_idx;
  logic [XLEN-1:0]   regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [IDXW-1:0]   rd_idx;

  // State register; reset always restarts the clear sweep.
  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_nxt;
  end

  // Leave CLEAR once the last register has been written.
  always_comb begin
    state_nxt = state;
    if (state == CLEAR && clr_idx == IDXW'(NREGS - 1)) state_nxt = READY;
  end

  // Clear pointer advances one register per cycle while sweeping.
  always_ff @(posedge clk) begin
    if (rst)                 clr_idx <= '0;
    else if (state == CLEAR) clr_idx <= clr_idx + IDXW'(1);
  end

  // Storage: no reset on the array itself, the sweep zeroes it. x0 never written.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR)
        regs[clr_idx] <= '0;
      else if (write_en && write_rd != '0)
        regs[write_rd] <= data_in;
    end
  end

  // Scoreboard: a write releases, a reserve sets; reserve is applied last so a
  // producer issued in the same cycle as the old result's writeback wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else if (state == READY) begin
      if (write_en)
        busy[write_rd] <= 1'b0;
      if (reserve_en && reserve_rd != '0)
        busy[reserve_rd] <= 1'b1;
    end
  end

  assign init_done = (state == READY);

  // Read ports: x0 hardwired to zero/not busy, optional same-cycle forwarding.
  always_comb begin
    rs_data = '0;
    rs_busy = '0;
    rd_idx  = '0;
    for (int k = 0; k < NREAD; k++) begin
      rd_idx = rs_idx[k*IDXW +: IDXW];
      if (state == READY && rd_idx != '0) begin
        if (BYPASS != 0 && write_en && write_rd == rd_idx) begin
          rs_data[k*XLEN +: XLEN] = data_in;
          rs_busy[k]              = 1'b0;
        end else begin
          rs_data[k*XLEN +: XLEN] = regs[rd_idx];
          rs_busy[k]              = busy[rd_idx];
        end
      end
    end
  end

  // Debug port shows committed contents only, never forwarded data.
  always_comb begin
    dbg_data = '0;
    if (state == READY && dbg_sel != '0) dbg_data = regs[dbg_sel];
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: drives a forwarding and a non-forwarding instance with the
// same stimulus and compares both against hand-computed expectations.
module tb_regfile_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NREAD = 3;
  localparam int IDXW  = 5;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREAD*IDXW-1:0] rs_idx;
  logic                  write_en;
  logic [IDXW-1:0]       write_rd;
  logic [XLEN-1:0]       data_in;
  logic                  reserve_en;
  logic [IDXW-1:0]       reserve_rd;
  logic [IDXW-1:0]       dbg_sel;

  logic [NREAD*XLEN-1:0] b_rs_data, n_rs_data;
  logic [NREAD-1:0]      b_rs_busy, n_rs_busy;
  logic [XLEN-1:0]       b_dbg, n_dbg;
  logic                  b_done, n_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .rs_idx(rs_idx), .rs_data(b_rs_data), .rs_busy(b_rs_busy),
    .write_en(write_en), .write_rd(write_rd), .data_in(data_in),
    .reserve_en(reserve_en), .reserve_rd(reserve_rd),
    .dbg_sel(dbg_sel), .dbg_data(b_dbg), .init_done(b_done));

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(0)) u_nob (
    .clk(clk), .rst(rst), .rs_idx(rs_idx), .rs_data(n_rs_data), .rs_busy(n_rs_busy),
    .write_en(write_en), .write_rd(write_rd), .data_in(data_in),
    .reserve_en(reserve_en), .reserve_rd(reserve_rd),
    .dbg_sel(dbg_sel), .dbg_data(n_dbg), .init_done(n_done));

  typedef struct packed {
    logic        we;
    logic [4:0]  wr;
    logic [31:0] din;
    logic        re;
    logic [4:0]  rr;
    logic [4:0]  r0, r1, r2;
    logic [31:0] eb0, eb1, eb2;
    logic [2:0]  ebb;
    logic [31:0] en0, en1, en2;
    logic [2:0]  enb;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    write_en = 1'b0; write_rd = '0; data_in = '0;
    reserve_en = 1'b0; reserve_rd = '0;
  endtask

  task automatic set_rs(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    rs_idx = {c, b, a};
  endtask

  // Counts edges after rst deassert until each instance reports init_done.
  task automatic clear_run(output int nb, output int nn);
    nb = 0; nn = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (b_done && nb == 0) nb = i;
      if (n_done && nn == 0) nn = i;
      if (i == 10) begin
        chk("clr_rs_data_b", 96'(b_rs_data), 96'd0);
        chk("clr_rs_busy_n", 96'(n_rs_busy), 96'd0);
        chk("clr_dbg_b", 96'(b_dbg), 96'd0);
      end
      if (nb != 0 && nn != 0) break;
    end
  endtask

  task automatic dbg_sweep(input string tag);
    int bad;
    bad = 0;
    for (int s = 0; s < NREGS; s++) begin
      dbg_sel = s[4:0];
      #1;
      if (b_dbg !== '0 || n_dbg !== '0) bad++;
    end
    chk(tag, 96'(bad), 96'd0);
    dbg_sel = '0;
  endtask

  initial begin
    int nb, nn;
    //          we   wr     din            re   rr     r0    r1    r2    eb0           eb1           eb2           ebb     en0           en1           en2           enb
    vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 3'b000, 32'h0,        32'h0,        32'h0,        3'b000};
    vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 3'b000, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 3'b000};
    vecs[2]  = '{1'b1, 5'd0, 32'h1234,     1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        32'h0,        3'b000, 32'h0,        32'h0,        32'h0,        3'b000};
    vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        32'h0,        3'b000, 32'h0,        32'h0,        32'h0,        3'b000};
    vecs[4]  = '{1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd0, 5'd7, 5'd5, 32'h0,        32'hA5A5A5A5, 32'hDEADBEEF, 3'b000, 32'h0,        32'h0,        32'hDEADBEEF, 3'b000};
    vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd7, 5'd5, 32'h0,        32'hA5A5A5A5, 32'hDEADBEEF, 3'b000, 32'h0,        32'hA5A5A5A5, 32'hDEADBEEF, 3'b000};
    vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 5'd3, 5'd3, 5'd3, 32'h0,        32'h0,        32'h0,        3'b000, 32'h0,        32'h0,        32'h0,        3'b000};
    vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd3, 5'd3, 32'h0,        32'h0,        32'h0,        3'b111, 32'h0,        32'h0,        32'h0,        3'b111};
    vecs[8]  = '{1'b1, 5'd3, 32'h9,        1'b0, 5'd0, 5'd3, 5'd3, 5'd3, 32'h9,        32'h9,        32'h9,        3'b000, 32'h0,        32'h0,        32'h0,        3'b111};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd3, 5'd3, 32'h9,        32'h9,        32'h9,        3'b000, 32'h9,        32'h9,        32'h9,        3'b000};
    vecs[10] = '{1'b1, 5'd3, 32'h77,       1'b1, 5'd3, 5'd3, 5'd3, 5'd3, 32'h77,       32'h77,       32'h77,       3'b000, 32'h9,        32'h9,        32'h9,        3'b000};
    vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd3, 5'd3, 32'h77,       32'h77,       32'h77,       3'b111, 32'h77,       32'h77,       32'h77,       3'b111};
    vecs[12] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        32'h0,        3'b000, 32'h0,        32'h0,        32'h0,        3'b000};
    vecs[13] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd3, 5'd7, 32'h0,        32'h77,       32'hA5A5A5A5, 3'b010, 32'h0,        32'h77,       32'hA5A5A5A5, 3'b010};
    vecs[14] = '{1'b1, 5'd3, 32'h1,        1'b1, 5'd4, 5'd3, 5'd4, 5'd5, 32'h1,        32'h0,        32'hDEADBEEF, 3'b000, 32'h77,       32'h0,        32'hDEADBEEF, 3'b001};
    vecs[15] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd4, 5'd5, 32'h1,        32'h0,        32'hDEADBEEF, 3'b010, 32'h1,        32'h0,        32'hDEADBEEF, 3'b010};
    vecs[16] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 5'd4, 5'd4, 5'd4, 32'h0,        32'h0,        32'h0,        3'b111, 32'h0,        32'h0,        32'h0,        3'b111};
    vecs[17] = '{1'b1, 5'd4, 32'h55,       1'b0, 5'd0, 5'd4, 5'd4, 5'd4, 32'h55,       32'h55,       32'h55,       3'b000, 32'h0,        32'h0,        32'h0,        3'b111};
    vecs[18] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd4, 5'd4, 5'd4, 32'h55,       32'h55,       32'h55,       3'b000, 32'h55,       32'h55,       32'h55,       3'b000};

    // Reset: outputs gated, scoreboard empty.
    rst = 1'b1; idle_inputs(); set_rs(5'd5, 5'd6, 5'd7); dbg_sel = 5'd5;
    tick(); tick();
    chk("rst_init_done", 96'({b_done, n_done}), 96'd0);
    chk("rst_rs_data_b", 96'(b_rs_data), 96'd0);
    chk("rst_rs_busy_b", 96'(b_rs_busy), 96'd0);
    chk("rst_dbg_n", 96'(n_dbg), 96'd0);

    // Clear with write/reserve of x9 held on throughout; both must be ignored.
    rst = 1'b0;
    write_en = 1'b1; write_rd = 5'd9; data_in = 32'hFFFF_FFFF;
    reserve_en = 1'b1; reserve_rd = 5'd9;
    clear_run(nb, nn);
    idle_inputs();
    chk("clr_latency_b", 96'(nb), 96'(NREGS));
    chk("clr_latency_n", 96'(nn), 96'(NREGS));
    #2;
    set_rs(5'd9, 5'd9, 5'd9);
    #1;
    chk("clr_we_ignored_b", 96'(b_rs_data), 96'd0);
    chk("clr_re_ignored_b", 96'(b_rs_busy), 96'd0);
    chk("clr_re_ignored_n", 96'(n_rs_busy), 96'd0);
    dbg_sweep("clr_dbg_sweep");
    tick();

    // Directed vectors, one cycle each; outputs checked before the edge.
    for (int i = 0; i < NVEC; i++) begin
      write_en = vecs[i].we; write_rd = vecs[i].wr; data_in = vecs[i].din;
      reserve_en = vecs[i].re; reserve_rd = vecs[i].rr;
      set_rs(vecs[i].r0, vecs[i].r1, vecs[i].r2);
      #3;
      chk($sformatf("v%0d_data_b", i), 96'(b_rs_data), {vecs[i].eb2, vecs[i].eb1, vecs[i].eb0});
      chk($sformatf("v%0d_busy_b", i), 96'(b_rs_busy), 96'(vecs[i].ebb));
      chk($sformatf("v%0d_data_n", i), 96'(n_rs_data), {vecs[i].en2, vecs[i].en1, vecs[i].en0});
      chk($sformatf("v%0d_busy_n", i), 96'(n_rs_busy), 96'(vecs[i].enb));
      tick();
    end
    idle_inputs();

    // Debug port: committed values, no forwarding of an in-flight write.
    dbg_sel = 5'd3;
    write_en = 1'b1; write_rd = 5'd3; data_in = 32'hCAFE;
    #2;
    chk("dbg_no_bypass_b", 96'(b_dbg), 96'h1);
    write_en = 1'b0;
    dbg_sel = 5'd5;
    #1;
    chk("dbg_x5_n", 96'(n_dbg), 96'hDEADBEEF);
    tick();
    chk("dbg_after_write_b", 96'(b_dbg), 96'hDEADBEEF);

    // Mid-operation reset: x4 busy holding 0x55, rst collides with write/reserve.
    reserve_en = 1'b1; reserve_rd = 5'd4;
    tick();
    reserve_en = 1'b0;
    set_rs(5'd4, 5'd4, 5'd4);
    #2;
    chk("mid_busy_before_b", 96'(b_rs_busy), 96'(3'b111));
    chk("mid_data_before_n", 96'(n_rs_data), {32'h55, 32'h55, 32'h55});
    rst = 1'b1;
    write_en = 1'b1; write_rd = 5'd4; data_in = 32'hAA;
    reserve_en = 1'b1; reserve_rd = 5'd4;
    tick();
    rst = 1'b0; idle_inputs();
    chk("mid_rst_gate_b", 96'({b_done, b_rs_busy}), 96'd0);
    clear_run(nb, nn);
    chk("mid_clr_latency_b", 96'(nb), 96'(NREGS));
    chk("mid_clr_latency_n", 96'(nn), 96'(NREGS));
    #2;
    chk("mid_x4_data_b", 96'(b_rs_data), 96'd0);
    chk("mid_x4_busy_b", 96'(b_rs_busy), 96'd0);
    chk("mid_x4_data_n", 96'(n_rs_data), 96'd0);
    chk("mid_x4_busy_n", 96'(n_rs_busy), 96'd0);
    dbg_sweep("mid_dbg_sweep");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with N combinational read ports, one write port, optional write-to-read bypass, a per-register busy scoreboard, and a sequential post-reset clear engine. It replaces the fixed 3-read debug-tap register file in the decode stage. Decode reads operands and reserves destinations at issue. Writeback writes results and releases reservations. A single debug read port replaces the hard-wired register taps.

## Interface
- XLEN, 32, register width in bits
- NREGS, 32, number of architectural registers; power of two, at least 2
- NREAD, 3, number of read ports
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching reads; 0 = no forwarding
- IDXW (localparam), $clog2(NREGS), register index width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- rs_idx  in  NREAD*IDXW  read indices; port k uses bits [k*IDXW +: IDXW]
- rs_data  out  NREAD*XLEN  read data; port k uses bits [k*XLEN +: XLEN]
- rs_busy  out  NREAD  port k's register has an outstanding reservation
- write_en  in  1  write strobe
- write_rd  in  IDXW  write index
- data_in  in  XLEN  write data
- reserve_en  in  1  mark register busy (issue of a producer)
- reserve_rd  in  IDXW  register to reserve
- dbg_sel  in  IDXW  debug read index
- dbg_data  out  XLEN  debug read data; no bypass
- init_done  out  1  clear finished; block operational

## Operation
- The FSM has two states: CLEAR and READY.
  - rst=1 forces CLEAR, sets clr_idx=0, and clears all busy bits. This applies in any state, including mid-clear.
  - In CLEAR with rst=0, each cycle writes reg[clr_idx]<=0 and increments clr_idx. When clr_idx==NREGS-1, the FSM moves to READY.
  - READY holds until rst.
- During CLEAR:
  - write_en and reserve_en are ignored.
  - rs_data, rs_busy and dbg_data are forced to 0.
  - init_done is 0.
- Register x0:
  - Writes to index 0 are discarded.
  - A reservation of index 0 is discarded.
  - Reads of index 0 always return 0 with busy=0, even when BYPASS=1 and write_rd=0.
- Reads are combinational: rs_data[k] = reg[rs_idx[k]].
  - If BYPASS=1, write_en=1 and write_rd==rs_idx[k]!=0, then rs_data[k]=data_in and rs_busy[k]=0 in the same cycle.
  - Any number of ports may read the same index.
- Writes: with write_en=1 in READY, reg[write_rd]<=data_in and busy[write_rd]<=0 at the clock edge.
- Reserve: with reserve_en=1 in READY, busy[reserve_rd]<=1.
- Write and reserve to the same rd in the same cycle:
  - The data is written.
  - busy ends at 1, because the new producer wins.
- Write and reserve to different registers in the same cycle: both take effect.
- Reserving an already-busy register leaves it busy. There is no counting; one write releases it.
- A reservation does not change the stored data.

## Timing
- Reset values:
  - init_done=0.
  - All busy bits 0.
  - rs_data, rs_busy and dbg_data are 0 from the first rst edge until init_done rises.
  - Register contents are undefined until cleared.
- Clear latency: init_done=1 exactly NREGS rising edges after the first edge with rst=0. It is registered.
- Read latency: 0 cycles, combinational from rs_idx.
- Write visibility:
  - With BYPASS=1, visible in the same cycle.
  - With BYPASS=0, visible from the cycle after the write edge.
- busy set by a reserve: rs_busy reflects it from the cycle after the edge. There is no same-cycle effect.
- busy cleared by a write:
  - Same cycle if BYPASS=1.
  - Next cycle if BYPASS=0.
- No combinational path from reserve_* to any output.
- rst asserted in the same cycle as write_en or reserve_en: rst wins and nothing is recorded.

## Test plan
- Reset clear, NREGS=32: pulse rst for 1 cycle. Required:
  - init_done=0 for 31 cycles and goes to 1 on the 32nd edge.
  - All 32 registers read 0 via dbg_sel sweep.
  - write_en issued during CLEAR has no effect.
- Basic write/read: write x5=0xDEADBEEF. Required:
  - Next cycle, all 3 ports with rs_idx=5 read 0xDEADBEEF.
  - A write of 0x1234 to x0 leaves x0=0.
- Bypass: BYPASS=1, write x7=0xA5A5A5A5 while rs_idx[1]=7. Required: rs_data[1]=0xA5A5A5A5 in the same cycle.
  - Repeat with BYPASS=0. Required: old value in the same cycle, new value the cycle after.
- Scoreboard:
  1. Reserve x3. Required: rs_busy=1 next cycle.
  2. Write x3=9. Required: with BYPASS=1, busy=0 and data=9 in the same cycle; with BYPASS=0, both hold from the next cycle.
  3. Reserve and write x3 in the same cycle. Required: data updated and busy=1 after the edge.
- Reserve/read x0: reserve x0, then read x0. Required: rs_busy=0 and data=0 on all ports.
- Mid-operation reset: x4 busy and holding 0x55, then assert rst in the same cycle as a write to x4. Required:
  - Busy cleared and the write discarded.
  - A full clear sequence runs again.
  - x4 reads 0 after init_done.
